pool_result_writer: RTL and testbench
=====================================

# pool_result_writer

Write-side address generator for the max-pooling stage. It accepts pooled pixels as a valid/ready stream and stores each one into the pooled feature-map memory in row-major order. It covers one 13×13 output channel per start, beginning at a per-channel base address, and signals completion. It is the consumer-side counterpart of the stride-2 conv-output read address generator that feeds the pooling comparator.

## Interface
Parameters:
- DATA_W, 8, pooled pixel width
- ADDR_W, 10, memory address width
- N_OUT_R, 13, output rows per channel
- N_OUT_C, 13, output columns per channel

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a channel; sampled only in IDLE
- abort  in  1  synchronous abandon of the current channel
- ch_base  in  ADDR_W  channel base address; latched on accepted start
- in_valid  in  1  pooled pixel present
- in_data  in  DATA_W  pooled pixel
- in_ready  out  1  block can accept a pixel
- mem_we  out  1  write strobe, one cycle per pixel
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  DATA_W  write data
- row  out  ADDR_W  row index of the next pixel to accept
- col  out  ADDR_W  column index of the next pixel to accept
- busy  out  1  channel in progress (RUN or LAST)
- done  out  1  one-cycle pulse coincident with the final write

## Operation
- FSM states: IDLE, RUN, LAST.
- IDLE:
  - in_ready=0.
  - start=1 → latch ch_base, clear row, col and the linear offset lin, go to RUN.
- RUN:
  - in_ready=1.
  - Beat = in_valid & in_ready at a clock edge.
  - On a beat: register mem_we=1, mem_addr=(base+lin) mod 2^ADDR_W, mem_wdata=in_data.
  - Then lin+=1 and col+=1.
  - When col==N_OUT_C-1: col→0 and row+=1.
  - A beat at row==N_OUT_R-1, col==N_OUT_C-1 → go to LAST instead of advancing.
- LAST:
  - in_ready=0; final mem_we and done=1 are asserted this cycle.
  - Unconditionally return to IDLE, with row, col and lin cleared.
- Address arithmetic:
  - lin is an incremental counter; no multiplier.
  - Sum is truncated to ADDR_W (wraps silently).
- start outside IDLE is ignored.
- abort in RUN or LAST → IDLE next edge, counters cleared, no done.
  - A write already registered still completes its cycle.
  - abort has priority over a coincident beat: that beat is not written.
- in_valid while in_ready=0: no effect, the data is not consumed.
- Reset (asynchronous, any time):
  - state IDLE.
  - mem_we, mem_addr, mem_wdata, row, col, busy, done, in_ready all 0.
  - Latched base cleared.

## Timing
- Accept-to-write latency: 1 cycle. Beat at edge k → mem_we high during cycle k..k+1 with that beat's address and data.
- Throughput: 1 pixel/cycle in RUN. Bubbles on in_valid stall counters without gaps in addressing.
- mem_we is never high in two consecutive cycles unless beats were consecutive.
- start→first in_ready: 1 cycle (in_ready rises the cycle after start is sampled).
- Last beat at edge k → during cycle k..k+1: mem_we=1, addr=base+N_OUT_R*N_OUT_C-1, done=1, busy=1.
  - Edge k+1 → IDLE.
  - A new start is sampled at edge k+2 at the earliest.
- busy=1 from the edge sampling start up to and including the LAST cycle.
- Outputs are registered except in_ready, which is decoded directly from state.

## Structure
- Package cnn_pool_pkg holds:
  - state enum {IDLE, RUN, LAST}
  - default N_OUT_R/N_OUT_C (13)
  - POOL_PIXELS = N_OUT_R*N_OUT_C
- One sub-module, pool_rc_counter, owns row/col/lin:
  - Inputs: clr, inc.
  - Outputs: row, col, lin, last, where last = row==N_OUT_R-1 && col==N_OUT_C-1.
  - Wrap logic lives there.
- The top holds the FSM, base latch and registered write port.

## Test plan
- Continuous frame: start with ch_base=0, 169 back-to-back beats, data=addr[7:0].
  - Expect 169 writes at addr 0..168 in order.
  - done pulses with addr 168, then IDLE.
- Row wrap: ch_base=200, 14 beats.
  - Beat 13 lands at addr 212 with row=0, col=12 pre-beat.
  - Beat 14 lands at addr 213; then row=1, col=1.
- Gappy input: in_valid toggling 1-0-0-1 pseudo-randomly over a full frame.
  - Addresses contiguous, write count exactly 169, no write in bubble cycles.
- Address wrap: ch_base=1000, ADDR_W=10.
  - Beat 24 → addr 1023, beat 25 → addr 0, final addr 144.
- Control hazards:
  - start during RUN: ignored.
  - abort at beat 50: IDLE, no done, busy=0.
  - rst asserted mid-frame (async, between edges): all outputs 0 immediately.
  - Fresh start afterwards: writes from ch_base.
- Back-to-back channels:
  - start held high: second channel begins at edge k+2.
  - New ch_base=169 gives addr 169..337.

Source files
------------

// File: rtl/cnn_pool_pkg.sv
// Shared types and defaults for the max-pooling stage.
package cnn_pool_pkg;

  // Result-writer control states.
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StLast
  } pool_state_e;

  // Default pooled output geometry (one channel).
  localparam int unsigned POOL_N_OUT_R = 13;
  localparam int unsigned POOL_N_OUT_C = 13;
  localparam int unsigned POOL_PIXELS  = POOL_N_OUT_R * POOL_N_OUT_C;

endpackage

// File: rtl/pool_rc_counter.sv
// Row/column/linear position tracker for one pooled output channel.
module pool_rc_counter #(
  parameter int unsigned N_OUT_R = 13,
  parameter int unsigned N_OUT_C = 13,
  parameter int unsigned CNT_W   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] lin,
  output logic             last
);

  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] lin_q, lin_d;
  logic             col_max;

  assign col_max = (col_q == CNT_W'(N_OUT_C - 1));
  assign last    = (row_q == CNT_W'(N_OUT_R - 1)) && col_max;

  assign row = row_q;
  assign col = col_q;
  assign lin = lin_q;

  // Next position: clear wins, otherwise advance with column wrap into the next row.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    lin_d = lin_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
      lin_d = '0;
    end else if (inc) begin
      lin_d = lin_q + 1'b1;
      if (col_max) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
      lin_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      lin_q <= lin_d;
    end
  end

endmodule

// File: rtl/pool_result_writer.sv
// Stores a stream of pooled pixels into feature-map memory, row-major from a channel base.
module pool_result_writer
  import cnn_pool_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned N_OUT_R = POOL_N_OUT_R,
  parameter int unsigned N_OUT_C = POOL_N_OUT_C
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] ch_base,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  output logic              busy,
  output logic              done
);

  pool_state_e       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              beat;
  logic              cnt_clr;
  logic              cnt_inc;
  logic              cnt_last;
  logic [ADDR_W-1:0] lin;

  pool_rc_counter #(
    .N_OUT_R (N_OUT_R),
    .N_OUT_C (N_OUT_C),
    .CNT_W   (ADDR_W)
  ) u_rc_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .row  (row),
    .col  (col),
    .lin  (lin),
    .last (cnt_last)
  );

  // in_ready is decoded straight from state so a beat is known within the cycle.
  assign in_ready = (state_q == StRun);
  assign beat     = in_valid & in_ready;

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Control FSM and next write-port values; abort outranks a coincident beat.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          base_d  = ch_base;
          cnt_clr = 1'b1;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
          cnt_clr = 1'b1;
        end else if (beat) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = base_q + lin;  // wraps modulo 2^ADDR_W
          mem_wdata_d = in_data;
          if (cnt_last) begin
            state_d = StLast;
            done_d  = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      StLast: begin
        state_d = StIdle;
        cnt_clr = 1'b1;
      end
      default: begin
        state_d = StIdle;
        cnt_clr = 1'b1;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  // State, base latch and registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_pool_result_writer.sv
// Directed self-checking bench for pool_result_writer.
module tb_pool_result_writer;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] ch_base = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  pool_result_writer #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .N_OUT_R (13),
    .N_OUT_C (13)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .ch_base   (ch_base),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .row       (row),
    .col       (col),
    .busy      (busy),
    .done      (done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Write log captured mid-cycle, plus writes that had no beat in the previous cycle.
  logic [ADDR_W-1:0] wr_addr[$];
  logic [DATA_W-1:0] wr_data[$];
  int   done_cnt  = 0;
  int   spurious  = 0;
  logic beat_prev = 1'b0;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      if (!beat_prev) spurious <= spurious + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    beat_prev <= in_valid && in_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_ch(input logic [ADDR_W-1:0] base, input bit hold);
    start   = 1'b1;
    ch_base = base;
    tick();
    if (!hold) start = 1'b0;
  endtask

  // n consecutive beats; data is the low byte of the address each pixel should land at.
  task automatic beats(input int n, input logic [ADDR_W-1:0] base, input int first);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(int'(base) + first + i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic check_seq(input string tag, input int w0, input int n,
                           input logic [ADDR_W-1:0] base);
    int bad;
    logic [ADDR_W-1:0] exp_a;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      exp_a = 10'(int'(base) + i);
      if (w0 + i >= wr_addr.size()) bad++;
      else if (wr_addr[w0+i] !== exp_a || wr_data[w0+i] !== exp_a[7:0]) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, s0, nb, cyc;
    bit will_beat;

    // Reset state
    #12;
    check("rst_mem_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_row", row, 0);
    check("rst_col", col, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Continuous frame from base 0
    w0 = wr_addr.size(); d0 = done_cnt;
    start_ch(10'd0, 1'b0);
    check("t1_busy", busy, 1);
    check("t1_ready", in_ready, 1);
    check("t1_row0", row, 0);
    beats(168, 10'd0, 0);
    check("t1_row_pre", row, 12);
    check("t1_col_pre", col, 12);
    beats(1, 10'd0, 168);
    check("t1_last_we", mem_we, 1);
    check("t1_last_addr", mem_addr, 168);
    check("t1_last_done", done, 1);
    check("t1_last_busy", busy, 1);
    check("t1_last_ready", in_ready, 0);
    tick();
    check("t1_idle_busy", busy, 0);
    check("t1_idle_done", done, 0);
    check("t1_idle_we", mem_we, 0);
    check("t1_idle_row", row, 0);
    check("t1_count", wr_addr.size() - w0, 169);
    check_seq("t1_seq", w0, 169, 10'd0);
    check("t1_done_cnt", done_cnt - d0, 1);

    // Row wrap at base 200
    w0 = wr_addr.size(); d0 = done_cnt;
    start_ch(10'd200, 1'b0);
    beats(12, 10'd200, 0);
    check("t2_row_pre13", row, 0);
    check("t2_col_pre13", col, 12);
    beats(2, 10'd200, 12);
    check("t2_row_post", row, 1);
    check("t2_col_post", col, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t2_abort_busy", busy, 0);
    check("t2_count", wr_addr.size() - w0, 14);
    check("t2_addr13", wr_addr[w0+12], 212);
    check("t2_addr14", wr_addr[w0+13], 213);
    check("t2_no_done", done_cnt - d0, 0);

    // Gappy input over a full frame
    w0 = wr_addr.size(); d0 = done_cnt; s0 = spurious;
    start_ch(10'd5, 1'b0);
    nb = 0; cyc = 0;
    while (nb < 169 && cyc < 2000) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'(5 + nb);
      will_beat = in_valid && in_ready;
      tick();
      if (will_beat) nb++;
      cyc++;
    end
    in_valid = 1'b0;
    check("t3_beats", nb, 169);
    tick();
    check("t3_count", wr_addr.size() - w0, 169);
    check_seq("t3_seq", w0, 169, 10'd5);
    check("t3_spurious", spurious - s0, 0);
    check("t3_done_cnt", done_cnt - d0, 1);
    check("t3_idle_busy", busy, 0);

    // Address wrap at base 1000
    w0 = wr_addr.size();
    start_ch(10'd1000, 1'b0);
    beats(169, 10'd1000, 0);
    tick();
    check("t4_addr24", wr_addr[w0+23], 1023);
    check("t4_addr25", wr_addr[w0+24], 0);
    check("t4_addr_final", wr_addr[w0+168], 144);
    check_seq("t4_seq", w0, 169, 10'd1000);

    // start during RUN ignored, abort at beat 50
    w0 = wr_addr.size(); d0 = done_cnt;
    start_ch(10'd300, 1'b0);
    beats(20, 10'd300, 0);
    start   = 1'b1;
    ch_base = 10'd500;
    beats(10, 10'd300, 20);
    start = 1'b0;
    check("t5_busy_mid", busy, 1);
    beats(20, 10'd300, 30);
    in_valid = 1'b1;
    in_data  = 8'(350);
    abort    = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    check("t5_abort_busy", busy, 0);
    check("t5_abort_ready", in_ready, 0);
    check("t5_abort_done", done, 0);
    check("t5_abort_we", mem_we, 0);
    check("t5_abort_row", row, 0);
    check("t5_abort_col", col, 0);
    check("t5_count", wr_addr.size() - w0, 50);
    check_seq("t5_seq", w0, 50, 10'd300);
    check("t5_no_done", done_cnt - d0, 0);

    // Async reset mid-frame, then fresh start
    start_ch(10'd0, 1'b0);
    beats(30, 10'd0, 0);
    check("t6_pre_we", mem_we, 1);
    #3;
    rst = 1'b1;
    #1;
    check("t6_rst_we", mem_we, 0);
    check("t6_rst_addr", mem_addr, 0);
    check("t6_rst_wdata", mem_wdata, 0);
    check("t6_rst_row", row, 0);
    check("t6_rst_col", col, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    w0 = wr_addr.size();
    start_ch(10'd400, 1'b0);
    beats(3, 10'd400, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_count", wr_addr.size() - w0, 3);
    check_seq("t6_seq", w0, 3, 10'd400);

    // Back-to-back channels with start held high
    w0 = wr_addr.size(); d0 = done_cnt;
    start_ch(10'd0, 1'b1);
    beats(169, 10'd0, 0);
    check("t7_done_k", done, 1);
    ch_base = 10'd169;
    tick();
    check("t7_k1_busy", busy, 0);
    check("t7_k1_ready", in_ready, 0);
    tick();
    check("t7_k2_busy", busy, 1);
    check("t7_k2_ready", in_ready, 1);
    start = 1'b0;
    beats(169, 10'd169, 0);
    tick();
    check("t7_count", wr_addr.size() - w0, 338);
    check("t7_second_first", wr_addr[w0+169], 169);
    check("t7_second_last", wr_addr[w0+337], 337);
    check_seq("t7_seq", w0, 338, 10'd0);
    check("t7_done_cnt", done_cnt - d0, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
